// File: rtl/spi_master.sv
// SPI frame master: 2-bit command + 8-bit payload out on MOSI, with an optional 8-bit read-back after a configurable gap.
// Optional busy-start error pulse is enabled by defining SPI_MASTER_BUSY_ERR_EN.
module spi_master #(
  parameter int unsigned READ_GAP = 2,
  localparam int unsigned FRAME_W = 10,
  localparam int unsigned DATA_W  = 8,
  localparam int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FRAME_W-1:0] din,
  input  logic              MISO,
  output logic              SS_n,
  output logic              MOSI,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
`ifdef SPI_MASTER_BUSY_ERR_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    RECV = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(READ_GAP - 1);
  localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(DATA_W - 1);

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [FRAME_W-1:0]  frame, frame_next;
  logic [DATA_W-1:0]   rx, rx_next;
  logic                is_read, is_read_next;
  logic                ss_n_next, mosi_next, busy_next, done_next, dout_valid_next;
  logic [DATA_W-1:0]   dout_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; output values are computed for the cycle being entered so they can be registered
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    frame_next      = frame;
    rx_next         = rx;
    is_read_next    = is_read;
    ss_n_next       = 1'b0;
    mosi_next       = 1'b0;
    busy_next       = 1'b1;
    done_next       = 1'b0;
    dout_valid_next = 1'b0;
    dout_next       = dout;

    case (state)
      IDLE: begin
        ss_n_next = 1'b1;
        busy_next = 1'b0;
        if (start) begin
          state_next   = SEL;
          frame_next   = din;
          is_read_next = (din[FRAME_W-1 -: 2] == 2'b11);
          cnt_next     = '0;
          ss_n_next    = 1'b0;
          busy_next    = 1'b1;
        end
      end

      SEL: begin
        state_next = SEND;
        cnt_next   = '0;
        mosi_next  = frame[FRAME_W-1];
        frame_next = {frame[FRAME_W-2:0], 1'b0};
      end

      SEND: begin
        if (cnt == SEND_LAST) begin
          cnt_next = '0;
          if (is_read) begin
            state_next = GAP;
          end else begin
            state_next = FIN;
            ss_n_next  = 1'b1;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next   = cnt + CNT_W'(1);
          mosi_next  = frame[FRAME_W-1];
          frame_next = {frame[FRAME_W-2:0], 1'b0};
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_next   = '0;
          state_next = RECV;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      RECV: begin
        rx_next = {rx[DATA_W-2:0], MISO};
        if (cnt == RECV_LAST) begin
          cnt_next        = '0;
          state_next      = FIN;
          ss_n_next       = 1'b1;
          done_next       = 1'b1;
          dout_valid_next = 1'b1;
          dout_next       = {rx[DATA_W-2:0], MISO};
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      FIN: begin
        state_next = IDLE;
        ss_n_next  = 1'b1;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = IDLE;
        ss_n_next  = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs; reset raises SS_n without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      frame      <= '0;
      rx         <= '0;
      is_read    <= 1'b0;
      SS_n       <= 1'b1;
      MOSI       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      cnt        <= cnt_next;
      frame      <= frame_next;
      rx         <= rx_next;
      is_read    <= is_read_next;
      SS_n       <= ss_n_next;
      MOSI       <= mosi_next;
      busy       <= busy_next;
      done       <= done_next;
      dout_valid <= dout_valid_next;
      dout       <= dout_next;
    end
  end

`ifdef SPI_MASTER_BUSY_ERR_EN
  // Flags a start request that arrives while a frame is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= start && (state != IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected frames, a negedge monitor checks each completed frame.
module tb_spi_master;

  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] din = '0;
  logic       MISO = 1'b0;
  logic       SS_n, MOSI, busy, done, dout_valid;
  logic [7:0] dout;
`ifdef SPI_MASTER_BUSY_ERR_EN
  logic       err;
  int         err_cnt = 0;
`endif

  spi_master #(.READ_GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .MISO(MISO),
    .SS_n(SS_n), .MOSI(MOSI), .busy(busy), .done(done),
    .dout(dout), .dout_valid(dout_valid)
`ifdef SPI_MASTER_BUSY_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] din;
    int         len;
    logic       dv;
    logic [7:0] dout;
    int         gap;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_dout = 8'h00;
  logic [7:0] slave_byte = 8'h00;
  int         low_cnt = 0;
  int         high_cnt = 0;
  int         last_gap = 0;
  int         frames_started = 0;
  int         frames_done = 0;
  logic [31:0] mosi_cap = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model of one frame, derived from the command bits
  task automatic push_exp(input logic [9:0] d, input logic [7:0] sb, input int gap);
    exp_t e;
    logic rd;
    rd = (d[9:8] == 2'b11);
    if (rd) model_dout = sb;
    e.din  = d;
    e.len  = rd ? (19 + G) : 11;
    e.dv   = rd;
    e.dout = model_dout;
    e.gap  = gap;
    q.push_back(e);
  endtask

  // Monitor + slave model, all sampled away from the rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt  = 0;
      high_cnt = 0;
      mosi_cap = '0;
      MISO     = 1'($urandom);
    end else begin
`ifdef SPI_MASTER_BUSY_ERR_EN
      if (err) err_cnt++;
`endif
      if (done) begin
        chk("expected_frame_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_t e;
          logic [31:0] em;
          e  = q.pop_front();
          em = '0;
          for (int k = 0; k < 10; k++) em[1+k] = e.din[9-k];
          chk("ss_low_len", 32'(low_cnt), 32'(e.len));
          chk("mosi_seq", mosi_cap, em);
          chk("dout_valid", 32'(dout_valid), 32'(e.dv));
          chk("dout", 32'(dout), 32'(e.dout));
          chk("busy_in_fin", 32'(busy), 32'd1);
          if (e.gap != 0) chk("ss_high_gap", 32'(last_gap), 32'(e.gap));
        end
        frames_done++;
      end
      if (!SS_n) begin
        int j;
        if (low_cnt == 0) begin
          last_gap = high_cnt;
          frames_started++;
        end
        if (low_cnt < 32) mosi_cap[low_cnt] = MOSI;
        j = low_cnt - (11 + G);
        MISO = (j >= 0 && j < 8) ? slave_byte[7-j] : 1'($urandom);
        low_cnt++;
        high_cnt = 0;
      end else begin
        low_cnt  = 0;
        mosi_cap = '0;
        high_cnt++;
        MISO     = 1'($urandom);
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic issue(input logic [9:0] d, input logic [7:0] sb);
    push_exp(d, sb, 0);
    slave_byte = sb;
    din   = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    din = $urandom;
  endtask

  initial begin
    int base;
    int n;

    // Reset state
    #12;
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Write address frame
    issue(10'b00_1010_0101, 8'h00);
    wait_frames(1, 60);
    repeat (2) @(posedge clk); #1;

    // Reset during SEND cycle 4
    din = 10'b10_1100_0011;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ss_n", 32'(SS_n), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_dout", 32'(dout), 32'd0);
    repeat (3) @(posedge clk);
    model_dout = 8'h00;
    chk("rst_hold_done", 32'(done), 32'd0);
    // Start already asserted when reset releases
    push_exp(10'b00_0011_1100, 8'h00, 0);
    din   = 10'b00_0011_1100;
    start = 1'b1;
    #6 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_start_after_rst", 32'(SS_n), 32'd0);
    start = 1'b0;
    wait_frames(2, 60);
    chk("no_done_from_aborted", 32'(frames_done), 32'd2);
    repeat (2) @(posedge clk); #1;

    // Read data frames, then a write that must keep dout
    issue(10'b11_0000_0000, 8'hC3);
    wait_frames(3, 80);
    repeat (3) @(posedge clk); #1;
    issue(10'b11_0000_0000, 8'h5A);
    wait_frames(4, 80);
    repeat (1) @(posedge clk); #1;
    issue(10'b01_1111_0000, 8'hFF);
    wait_frames(5, 60);
    repeat (2) @(posedge clk); #1;
    issue(10'b10_0110_1001, 8'h00);
    wait_frames(6, 60);
    repeat (2) @(posedge clk); #1;

    // Back-to-back: start held high across three frames
    base = frames_started;
    push_exp(10'b10_0110_1001, 8'h00, 0);
    push_exp(10'b10_0110_1001, 8'h00, 2);
    push_exp(10'b10_0110_1001, 8'h00, 2);
    din   = 10'b10_0110_1001;
    start = 1'b1;
    n = 0;
    while (frames_started < base + 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 start = 1'b0;
    chk("b2b_started", 32'(frames_started - base), 32'd3);
    wait_frames(9, 80);
    repeat (2) @(posedge clk); #1;

    // Start while busy, in RECV
`ifdef SPI_MASTER_BUSY_ERR_EN
    err_cnt = 0;
`endif
    issue(10'b11_0000_0000, 8'h96);
    n = 0;
    while (low_cnt < 11 + G + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    din   = 10'h3FF;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_frames(10, 60);
    repeat (30) @(posedge clk); #1;
    chk("busy_start_ignored", 32'(frames_started), 32'(base + 4));
`ifdef SPI_MASTER_BUSY_ERR_EN
    chk("err_pulses", 32'(err_cnt), 32'd1);
`endif
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("idle_ss_n", 32'(SS_n), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter READ_GAP, default 2, SHALL set the number of idle cycles between the last command bit and the first MISO sample (legal 1..7).
REQ-003 Port clk, input, 1 bit, SHALL be the rising-edge system clock.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Port start, input, 1 bit, SHALL request a frame and is sampled only in IDLE.
REQ-006 Port din, input, 10 bits, SHALL carry the frame word: din[9:8] is the command, din[7:0] is the payload.
REQ-007 Port MISO, input, 1 bit, SHALL be the serial data from the slave.
REQ-008 Port SS_n, output, 1 bit, SHALL be the active-low slave select, driven from a register.
REQ-009 Port MOSI, output, 1 bit, SHALL be the serial data to the slave, driven from a register.
REQ-010 Port busy, output, 1 bit, SHALL be high in every state except IDLE.
REQ-011 Port done, output, 1 bit, SHALL pulse for one cycle at the end of each frame.
REQ-012 Port dout, output, 8 bits, SHALL hold the byte read by the last read-data frame.
REQ-013 Port dout_valid, output, 1 bit, SHALL pulse together with done, for read-data frames only.

Function
REQ-014 The FSM SHALL have the states IDLE, SEL, SEND, GAP, RECV and FIN.
REQ-015 From IDLE, start=1 SHALL capture din into the shift register and move to SEL; SS_n SHALL be 0 from the next cycle.
REQ-016 SEL SHALL last 1 cycle, with SS_n=0 and MOSI=0.
REQ-017 SEND SHALL last 10 cycles; in SEND cycle k (k=0..9), MOSI SHALL equal captured din[9-k], MSB first, and SS_n SHALL be 0.
REQ-018 After SEND, command 2'b11 SHALL go to GAP; every other command SHALL go to FIN.
REQ-019 GAP SHALL last READ_GAP cycles, with SS_n=0 and MOSI=0.
REQ-020 RECV SHALL last 8 cycles; MISO SHALL be sampled on each rising edge and shifted into dout MSB first; SS_n SHALL be 0.
REQ-021 FIN SHALL last 1 cycle, with SS_n=1, MOSI=0, done=1 and busy=1, then return to IDLE.
REQ-022 In FIN, dout_valid SHALL be 1 only when the completed frame was a read-data frame; dout SHALL update only at that point.
REQ-023 Frame lengths with SS_n low SHALL be 11 cycles for commands 00, 01 and 10, and 19+READ_GAP cycles (21 at the default) for command 11.
REQ-024 start while busy=1 SHALL be ignored, and din changes after capture SHALL NOT affect the frame in progress.
REQ-025 SS_n SHALL be high for at least 2 cycles between frames (FIN plus IDLE).
REQ-026 MISO SHALL be ignored outside RECV.
REQ-027 dout SHALL hold its value across write frames and while idle.

Reset
REQ-028 While rst_n=0, the block SHALL force: state to IDLE, SS_n=1, MOSI=0, busy=0, done=0, dout_valid=0, dout=8'h00, and the bit counter to 0.
REQ-029 Reset asserted mid-frame SHALL raise SS_n immediately without waiting for a clock, and SHALL NOT produce a done pulse.
REQ-030 After reset release, the first start SHALL be accepted on the first rising edge at which rst_n=1.

Configuration
REQ-031 When the macro SPI_MASTER_BUSY_ERR_EN is defined, the block SHALL add an output port err (1 bit) that pulses for one cycle, in the cycle after any start=1 sampled while busy=1; the start SHALL still be ignored.
REQ-032 When SPI_MASTER_BUSY_ERR_EN is not defined, the err port and its logic SHALL be absent, and start while busy SHALL be silently ignored.

Verification
REQ-033 Write address: start with din=10'b00_1010_0101 -> SS_n low for 11 cycles, MOSI sequence 0,0,1,0,1,0,0,1,0,1 in SEND, then done=1 and dout_valid=0.
REQ-034 Read data: din=10'b11_0000_0000, with the slave model driving 8'hC3 on MISO in RECV -> SS_n low for 21 cycles, dout=8'hC3 and dout_valid=1 in FIN.
REQ-035 Back-to-back: start held at 1 continuously -> SS_n high for exactly 2 cycles between frames, with no frame lost or merged.
REQ-036 Reset mid-frame: rst_n=0 at SEND cycle 4 -> SS_n=1 asynchronously, busy=0, no done pulse, and dout remains 8'h00.
REQ-037 Start while busy: start pulse during RECV with din=10'h3FF -> the frame is unaffected; with SPI_MASTER_BUSY_ERR_EN defined, err=1 for one cycle.
REQ-038 Write frame after a read: the read returns 8'h5A, then a write frame with din=10'b01_1111_0000 -> dout stays 8'h5A and dout_valid=0.
